// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle controller and the ALU.
//   - 4-bit FSM state encodings (also exported on the debug `state` port)
//   - opcode / funct field constants
//   - alu_control codes (the ALU decodes the same values)
//   - alu_src_b and pc_source select codes
//   - ctrl_word_t: one bundle holding every control output, plus its idle value
package ctrl_pkg;

   // FSM state encodings
   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_EXECUTE   = 4'd6;
   localparam logic [3:0] S_ALU_WB    = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_ADDI_EXEC = 4'd10;
   localparam logic [3:0] S_ADDI_WB   = 4'd11;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   // ALU B input selects
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC input selects
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write_en;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_word_t;

   // Idle control word: nothing enabled, selects at 0, ALU defaults to ADD.
   function automatic ctrl_word_t ctrl_idle();
      ctrl_word_t w;
      w.pc_write_en = 1'b0;
      w.i_or_d      = 1'b0;
      w.mem_read    = 1'b0;
      w.mem_write   = 1'b0;
      w.ir_write    = 1'b0;
      w.reg_write   = 1'b0;
      w.reg_dst     = 1'b0;
      w.mem_to_reg  = 1'b0;
      w.alu_src_a   = 1'b0;
      w.alu_src_b   = SRCB_B;
      w.alu_control = ALU_ADD;
      w.pc_source   = PCSRC_ALU;
      w.illegal_op  = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// alu_control_decoder: combinational R-type funct -> ALU operation decode.
//   funct       in  6 : IR[5:0]
//   alu_control out 3 : ALU operation (ADD when funct is unsupported)
//   funct_valid out 1 : 1 when funct is one of the supported R-type codes
module alu_control_decoder
   import ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_valid
);

   // Map funct to ALU operation; unknown codes fall back to ADD and flag invalid
   always_comb begin
      alu_control = ALU_ADD;
      funct_valid = 1'b0;
      case (funct)
         FN_ADD: begin alu_control = ALU_ADD; funct_valid = 1'b1; end
         FN_SUB: begin alu_control = ALU_SUB; funct_valid = 1'b1; end
         FN_AND: begin alu_control = ALU_AND; funct_valid = 1'b1; end
         FN_OR:  begin alu_control = ALU_OR;  funct_valid = 1'b1; end
         FN_SLT: begin alu_control = ALU_SLT; funct_valid = 1'b1; end
         default: begin alu_control = ALU_ADD; funct_valid = 1'b0; end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FSM sequencing fetch/decode/execute/memory/
// writeback and driving every datapath select and write enable.
//   clk, reset        : single clock, synchronous active-high reset
//   opcode, funct     : IR fields, stable from DECODE until the next FETCH
//   zero              : ALU zero flag, used live in BRANCH
//   mem_ready         : memory completes the access (FETCH/MEM_READ/MEM_WRITE)
//   pc_write_en .. pc_source : datapath control, combinational from state
//   illegal_op        : one-cycle pulse on unsupported opcode/funct
//   state             : current FSM state (debug)
module multicycle_control
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write_en,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   logic [3:0] state_r;
   logic [3:0] next_state_s;
   ctrl_word_t ctrl_s;
   logic [2:0] dec_alu_control_s;
   logic       dec_funct_valid_s;

   alu_control_decoder u_alu_control_decoder (
      .funct       (funct),
      .alu_control (dec_alu_control_s),
      .funct_valid (dec_funct_valid_s)
   );

   // State register; the only storage element in the controller
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Per-state control word and next-state selection
   always_comb begin
      ctrl_s       = ctrl_idle();
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH: begin
            ctrl_s.mem_read  = 1'b1;
            ctrl_s.alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ctrl_s.ir_write    = 1'b1;
               ctrl_s.pc_write_en = 1'b1;
               next_state_s       = S_DECODE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is decoded
            ctrl_s.alu_src_b = SRCB_IMM_SH2;
            case (opcode)
               OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
               OP_RTYPE:     next_state_s = S_EXECUTE;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_ADDI:      next_state_s = S_ADDI_EXEC;
               OP_J:         next_state_s = S_JUMP;
               default: begin
                  ctrl_s.illegal_op = 1'b1;
                  next_state_s      = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = SRCB_IMM;
            if (opcode == OP_LW) begin
               next_state_s = S_MEM_READ;
            end else if (opcode == OP_SW) begin
               next_state_s = S_MEM_WRITE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_MEM_READ: begin
            ctrl_s.mem_read = 1'b1;
            ctrl_s.i_or_d   = 1'b1;
            if (mem_ready) begin
               next_state_s = S_MEM_WB;
            end else begin
               next_state_s = S_MEM_READ;
            end
         end
         S_MEM_WB: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
            next_state_s      = S_FETCH;
         end
         S_MEM_WRITE: begin
            ctrl_s.mem_write = 1'b1;
            ctrl_s.i_or_d    = 1'b1;
            if (mem_ready) begin
               next_state_s = S_FETCH;
            end else begin
               next_state_s = S_MEM_WRITE;
            end
         end
         S_EXECUTE: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = SRCB_B;
            if (dec_funct_valid_s) begin
               ctrl_s.alu_control = dec_alu_control_s;
               next_state_s       = S_ALU_WB;
            end else begin
               ctrl_s.alu_control = ALU_ADD;
               ctrl_s.illegal_op  = 1'b1;
               next_state_s       = S_FETCH;
            end
         end
         S_ALU_WB: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.reg_dst   = 1'b1;
            next_state_s     = S_FETCH;
         end
         S_BRANCH: begin
            // Live zero flag decides the PC write; ALUOut holds the target
            ctrl_s.alu_src_a   = 1'b1;
            ctrl_s.alu_src_b   = SRCB_B;
            ctrl_s.alu_control = ALU_SUB;
            ctrl_s.pc_source   = PCSRC_ALUOUT;
            ctrl_s.pc_write_en = zero;
            next_state_s       = S_FETCH;
         end
         S_JUMP: begin
            ctrl_s.pc_source   = PCSRC_JUMP;
            ctrl_s.pc_write_en = 1'b1;
            next_state_s       = S_FETCH;
         end
         S_ADDI_EXEC: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = SRCB_IMM;
            next_state_s     = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            ctrl_s.reg_write = 1'b1;
            next_state_s     = S_FETCH;
         end
         default: begin
            // Unreachable encodings recover to FETCH with everything idle
            ctrl_s       = ctrl_idle();
            next_state_s = S_FETCH;
         end
      endcase
   end

   // Enables and illegal_op are suppressed while reset is held
   assign pc_write_en = ctrl_s.pc_write_en & ~reset;
   assign mem_read    = ctrl_s.mem_read    & ~reset;
   assign mem_write   = ctrl_s.mem_write   & ~reset;
   assign ir_write    = ctrl_s.ir_write    & ~reset;
   assign reg_write   = ctrl_s.reg_write   & ~reset;
   assign illegal_op  = ctrl_s.illegal_op  & ~reset;
   assign i_or_d      = ctrl_s.i_or_d;
   assign reg_dst     = ctrl_s.reg_dst;
   assign mem_to_reg  = ctrl_s.mem_to_reg;
   assign alu_src_a   = ctrl_s.alu_src_a;
   assign alu_src_b   = ctrl_s.alu_src_b;
   assign alu_control = ctrl_s.alu_control;
   assign pc_source   = ctrl_s.pc_source;
   assign state       = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench. Stimulus walks each instruction
// through the phase list it should take, pushing one expected output record
// per cycle; a monitor pops and compares one record per cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_control;
   logic [3:0] state;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write_en(pc_write_en), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // Instruction encodings as the bench knows them
   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
   localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

   // Phase numbers equal the documented state numbers
   localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
   localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_J = 9, P_AE = 10, P_AW = 11;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_write_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
      logic       reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_source;
      logic       illegal_op;
   } obs_t;

   typedef struct {
      obs_t  e;
      string name;
   } exp_rec_t;

   exp_rec_t exp_q[$];
   int checks = 0;
   int passed = 0;

   function automatic logic known_op(input logic [5:0] op);
      return (op == T_R) || (op == T_LW) || (op == T_SW) ||
             (op == T_BEQ) || (op == T_ADDI) || (op == T_J);
   endfunction

   // {valid, alu code} for an R-type funct
   function automatic logic [3:0] alu_lookup(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b1_010;
         6'b100010: return 4'b1_011;
         6'b100100: return 4'b1_000;
         6'b100101: return 4'b1_001;
         6'b101010: return 4'b1_100;
         default:   return 4'b0_010;
      endcase
   endfunction

   // Expected outputs for one cycle spent in phase ph
   function automatic obs_t expect_obs(input int ph, input logic [5:0] op,
                                       input logic [5:0] fn, input logic mr,
                                       input logic z, input logic rst);
      obs_t o;
      logic [3:0] lk;
      o = '0;
      o.alu_control = 3'b010;
      o.st = ph[3:0];
      case (ph)
         P_F:   begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write_en = mr; end
         P_D:   begin o.alu_src_b = 2'b11; o.illegal_op = !known_op(op); end
         P_MA:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         P_MR:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
         P_MWB: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
         P_MW:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
         P_EX:  begin
            o.alu_src_a = 1'b1;
            lk = alu_lookup(fn);
            o.alu_control = lk[2:0];
            o.illegal_op = !lk[3];
         end
         P_AWB: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
         P_BR:  begin o.alu_src_a = 1'b1; o.alu_control = 3'b011; o.pc_source = 2'b01; o.pc_write_en = z; end
         P_J:   begin o.pc_source = 2'b10; o.pc_write_en = 1'b1; end
         P_AE:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         P_AW:  begin o.reg_write = 1'b1; end
         default: o = '0;
      endcase
      if (rst) begin
         o.pc_write_en = 1'b0; o.ir_write = 1'b0; o.reg_write = 1'b0;
         o.mem_read = 1'b0; o.mem_write = 1'b0; o.illegal_op = 1'b0;
      end
      return o;
   endfunction

   // Drive one cycle's inputs and queue the response they should produce
   task automatic cycle(input int ph, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic z, input logic rst);
      exp_rec_t r;
      @(posedge clk);
      #1;
      reset = rst; mem_ready = mr; zero = z; opcode = op; funct = fn;
      r.e = expect_obs(ph, op, fn, mr, z, rst);
      r.name = $sformatf("op%b_fn%b_ph%0d%s", op, fn, ph, rst ? "_rst" : "");
      exp_q.push_back(r);
   endtask

   // One whole instruction; stalls are extra mem_ready=0 cycles in wait phases
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fetch_stall, input int mem_stall, input logic z);
      int ph[$];
      int stalls;
      logic [3:0] lk;
      ph = '{P_F, P_D};
      lk = alu_lookup(fn);
      case (op)
         T_LW:   begin ph.push_back(P_MA); ph.push_back(P_MR); ph.push_back(P_MWB); end
         T_SW:   begin ph.push_back(P_MA); ph.push_back(P_MW); end
         T_R:    begin ph.push_back(P_EX); if (lk[3]) ph.push_back(P_AWB); end
         T_BEQ:  ph.push_back(P_BR);
         T_ADDI: begin ph.push_back(P_AE); ph.push_back(P_AW); end
         T_J:    ph.push_back(P_J);
         default: ;
      endcase
      foreach (ph[k]) begin
         stalls = (ph[k] == P_F) ? fetch_stall :
                  ((ph[k] == P_MR) || (ph[k] == P_MW)) ? mem_stall : 0;
         for (int s = 0; s < stalls; s++)
            cycle(ph[k], op, fn, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if ((ph[k] == P_F) || (ph[k] == P_MR) || (ph[k] == P_MW))
            cycle(ph[k], op, fn, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         else if (ph[k] == P_BR)
            cycle(ph[k], op, fn, 1'($urandom_range(0, 1)), z, 1'b0);
         else
            cycle(ph[k], op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   initial begin
      exp_rec_t r;
      obs_t act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            act = {state, pc_write_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source, illegal_op};
            checks++;
            if (act === r.e) passed++;
            else $display("FAIL %s: actual %h required %h", r.name, act, r.e);
         end
      end
   end

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [5];
      logic [5:0] op, fn;
      ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J, 6'b111111, 6'b010101};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'd0; funct = 6'd0;

      // Reset held two cycles, then the first fetch completes immediately
      cycle(P_F, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
      cycle(P_F, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);

      run_instr(T_LW, 6'd0, 0, 0, 1'b0);
      run_instr(T_R, 6'b100010, 0, 0, 1'b0);
      run_instr(T_BEQ, 6'd0, 0, 0, 1'b1);
      run_instr(T_BEQ, 6'd0, 0, 0, 1'b0);
      run_instr(T_SW, 6'd0, 0, 3, 1'b0);
      run_instr(6'b111111, 6'd0, 0, 0, 1'b0);
      run_instr(T_R, 6'b111111, 1, 0, 1'b0);
      run_instr(T_J, 6'd0, 2, 0, 1'b0);
      run_instr(T_ADDI, 6'd0, 0, 0, 1'b0);

      // Reset during MEM_READ: access abandoned, no writeback, back to FETCH
      cycle(P_F, T_LW, 6'd0, 1'b1, 1'b0, 1'b0);
      cycle(P_D, T_LW, 6'd0, 1'b1, 1'b0, 1'b0);
      cycle(P_MA, T_LW, 6'd0, 1'b1, 1'b0, 1'b0);
      cycle(P_MR, T_LW, 6'd0, 1'b0, 1'b0, 1'b0);
      cycle(P_MR, T_LW, 6'd0, 1'b1, 1'b0, 1'b1);
      run_instr(T_R, 6'b100101, 0, 0, 1'b0);

      // Randomized instruction stream with random stalls
      for (int i = 0; i < 150; i++) begin
         op = ops[$urandom_range(0, 7)];
         if (op == 6'b010101) op = 6'($urandom_range(0, 63));
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
         run_instr(op, fn, ($urandom_range(0, 3) == 0) ? 2 : 0,
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: actual %0d pending records, required 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
